// File: rtl/linear_network_collect_seq_if.sv
// Handshake bundle for linear_network_collect_seq.
// PE side: i_en, i_valid, i_data_bus, o_ready.
// Sink side: o_valid, o_data_bus, o_src, i_ready.
// The environment takes the master modport and the collector takes the slave modport.
interface linear_network_collect_seq_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_NODE   = 4
);
   localparam int SRC_WIDTH = $clog2(NUM_NODE);

   logic                           i_en;
   logic [NUM_NODE-1:0]            i_valid;
   logic [DATA_WIDTH*NUM_NODE-1:0] i_data_bus;
   logic [NUM_NODE-1:0]            o_ready;
   logic                           o_valid;
   logic [DATA_WIDTH-1:0]          o_data_bus;
   logic [SRC_WIDTH-1:0]           o_src;
   logic                           i_ready;

   modport master (
      output i_en, i_valid, i_data_bus, i_ready,
      input  o_ready, o_valid, o_data_bus, o_src
   );

   modport slave (
      input  i_en, i_valid, i_data_bus, i_ready,
      output o_ready, o_valid, o_data_bus, o_src
   );
endinterface

// File: rtl/linear_network_collect_seq.sv
// Linear gather chain. NUM_NODE PEs inject flits tagged with their node id into a
// registered chain that drains toward node 0. Node 0 presents one flit per cycle to the sink.
// When the sink stalls, the whole chain stalls, but bubbles upstream of the stall still compact.
// Optional feature: define LINEAR_COLLECT_FAIR_EN to make each stage alternate between
// upstream and local traffic. Without it, upstream traffic always has priority, so a PE
// can starve.
module linear_network_collect_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_NODE   = 4
) (
   input logic                         clk,
   input logic                         rst,
   linear_network_collect_seq_if.slave bus
);
   localparam int SRC_WIDTH = $clog2(NUM_NODE);

   logic [NUM_NODE-1:0]   v;
   logic [DATA_WIDTH-1:0] d    [NUM_NODE];
   logic [SRC_WIDTH-1:0]  s    [NUM_NODE];
   logic [DATA_WIDTH-1:0] d_up [NUM_NODE];
   logic [SRC_WIDTH-1:0]  s_up [NUM_NODE];

   logic [NUM_NODE-1:0]   v_up;
   logic [NUM_NODE-1:0]   drain;
   logic [NUM_NODE-1:0]   free;
   logic [NUM_NODE-1:0]   take_up;
   logic [NUM_NODE-1:0]   take_loc;
   logic [NUM_NODE-1:0]   ready_raw;
   logic                  pull;

`ifdef LINEAR_COLLECT_FAIR_EN
   // g[k] = 1 means the local PE gets the next turn at stage k.
   logic [NUM_NODE-1:0]   g;
`endif

   // View of the upstream neighbour of every stage. The last stage has no upstream neighbour.
   always_comb begin
      for (int k = 0; k < NUM_NODE - 1; k++) begin
         d_up[k] = d[k+1];
         s_up[k] = s[k+1];
      end
      d_up[NUM_NODE-1] = '0;
      s_up[NUM_NODE-1] = '0;
   end

   // Free/ready ripple from the sink upward: a stage can drain only if its downstream stage pulls.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      v_up      = {1'b0, v[NUM_NODE-1:1]};
      drain     = '0;
      free      = '0;
      take_up   = '0;
      take_loc  = '0;
      ready_raw = '0;
      // NOTE: blocking assignments are needed here, because pull carries each stage's result into the next loop iteration.
      pull      = bus.i_ready;
      for (int k = 0; k < NUM_NODE; k++) begin
         drain[k] = bus.i_en & v[k] & pull;
         free[k]  = ~v[k] | drain[k];
`ifdef LINEAR_COLLECT_FAIR_EN
         take_up[k]   = bus.i_en & free[k] & v_up[k] & ~(g[k] & bus.i_valid[k]);
         ready_raw[k] = bus.i_en & free[k] & (~v_up[k] | g[k]);
`else
         take_up[k]   = bus.i_en & free[k] & v_up[k];
         ready_raw[k] = bus.i_en & free[k] & ~v_up[k];
`endif
         take_loc[k] = ready_raw[k] & bus.i_valid[k];
         pull        = take_up[k];
      end
   end

   // Slot registers: load from upstream, load from the local PE, or clear on drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= '0;
         // NOTE: payload slots are reset as well, so the output bus reads zero out of reset without any clock.
         for (int k = 0; k < NUM_NODE; k++) begin
            d[k] <= '0;
            s[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_NODE; k++) begin
            if (take_up[k]) begin
               v[k] <= 1'b1;
               d[k] <= d_up[k];
               s[k] <= s_up[k];
            end else if (take_loc[k]) begin
               v[k] <= 1'b1;
               d[k] <= bus.i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
               s[k] <= SRC_WIDTH'(k);
            end else if (drain[k]) begin
               v[k] <= 1'b0;
               d[k] <= '0;
               s[k] <= '0;
            end
         end
      end
   end

`ifdef LINEAR_COLLECT_FAIR_EN
   // Grant toggle: after upstream wins against a waiting PE, the PE gets the next turn.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         g <= '0;
      end else begin
         for (int k = 0; k < NUM_NODE; k++) begin
            if (take_loc[k]) begin
               g[k] <= 1'b0;
            end else if (take_up[k] & bus.i_valid[k]) begin
               g[k] <= 1'b1;
            end
         end
      end
   end
`endif

   assign bus.o_ready    = ready_raw & ~{NUM_NODE{rst}};
   assign bus.o_valid    = bus.i_en & v[0];
   assign bus.o_data_bus = bus.o_valid ? d[0] : '0;
   assign bus.o_src      = bus.o_valid ? s[0] : '0;
endmodule
